// File: rtl/swervolf_pkg.sv
// rtl/swervolf_pkg.sv - shared types and helpers for the SweRVolf reset sequencer
package swervolf_pkg;

  // Sequencer states; the encoding is what syscon reads back on o_state.
  typedef enum logic [2:0] {
    S_LOCK  = 3'd0,
    S_PHOLD = 3'd1,
    S_CAL   = 3'd2,
    S_CHOLD = 3'd3,
    S_RUN   = 3'd4,
    S_FAIL  = 3'd5
  } state_e;

  // Bit positions inside the one-hot reset cause vector.
  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_LOCK = 1;
  localparam int CAUSE_WDT  = 2;
  localparam int CAUSE_SW   = 3;

  // Shared counter width: enough for the largest count, plus one bit of headroom.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

  // One-hot cause vector with only the given bit set.
  function automatic logic [3:0] cause_bit(input int idx);
    logic [3:0] v;
    logic [1:0] i;
    i = idx[1:0];
    v = 4'b0000;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/swervolf_rst_seq.sv
// rtl/swervolf_rst_seq.sv - clk25 reset sequencer: lock, periph/DDR, calibration, core
module swervolf_rst_seq
  import swervolf_pkg::*;
#(
  parameter int LOCK_FILTER = 16,
  parameter int PERIPH_HOLD = 32,
  parameter int CORE_HOLD   = 64,
  parameter int CAL_TIMEOUT = 1048576
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pll_locked,
  input  logic       i_calib_done,
  input  logic       i_wdt_bite,
  input  logic       i_sw_rst,
  output logic       o_rst_periph,
  output logic       o_rst_ddr,
  output logic       o_rst_core,
  output logic       o_ready,
  output logic       o_cal_fail,
  output logic [3:0] o_cause,
  output logic [2:0] o_state
);

  localparam int CNT_W = cnt_width(LOCK_FILTER, PERIPH_HOLD, CORE_HOLD, CAL_TIMEOUT);

  // Terminal counts: a state entered on edge E leaves on edge E+N.
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] PH_LAST   = CNT_W'(PERIPH_HOLD - 1);
  localparam logic [CNT_W-1:0] CH_LAST   = CNT_W'(CORE_HOLD - 1);
  localparam logic [CNT_W-1:0] CAL_LAST  = CNT_W'(CAL_TIMEOUT - 1);

  state_e             state;
  logic [CNT_W-1:0]   cnt;

  assign o_state = state;

  // Single sequencer FSM; all outputs are registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_LOCK;
      cnt          <= '0;
      o_rst_periph <= 1'b1;
      o_rst_ddr    <= 1'b1;
      o_rst_core   <= 1'b1;
      o_ready      <= 1'b0;
      o_cal_fail   <= 1'b0;
      o_cause      <= cause_bit(CAUSE_POR);
    end else if (state != S_LOCK && !i_pll_locked) begin
      // Lock loss outranks everything but board reset and restarts the whole chain.
      state        <= S_LOCK;
      cnt          <= '0;
      o_rst_periph <= 1'b1;
      o_rst_ddr    <= 1'b1;
      o_rst_core   <= 1'b1;
      o_ready      <= 1'b0;
      o_cause      <= cause_bit(CAUSE_LOCK);
    end else begin
      case (state)
        S_LOCK: begin
          // The shared counter doubles as the lock glitch filter.
          if (!i_pll_locked) begin
            cnt <= '0;
          end else if (cnt == LOCK_LAST) begin
            state <= S_PHOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PHOLD: begin
          if (cnt == PH_LAST) begin
            state        <= S_CAL;
            cnt          <= '0;
            o_rst_periph <= 1'b0;
            o_rst_ddr    <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CAL: begin
          if (i_calib_done) begin
            state <= S_CHOLD;
            cnt   <= '0;
          end else if (cnt == CAL_LAST) begin
            state      <= S_FAIL;
            cnt        <= '0;
            o_cal_fail <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CHOLD: begin
          if (cnt == CH_LAST) begin
            state      <= S_RUN;
            cnt        <= '0;
            o_rst_core <= 1'b0;
            o_ready    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          // Core-only re-sequence; watchdog wins over software when both arrive.
          if (i_wdt_bite || i_sw_rst) begin
            state      <= S_CHOLD;
            cnt        <= '0;
            o_rst_core <= 1'b1;
            o_ready    <= 1'b0;
            o_cause    <= i_wdt_bite ? cause_bit(CAUSE_WDT) : cause_bit(CAUSE_SW);
          end
        end
        S_FAIL: begin
          // Parked with the core in reset until board reset or lock loss.
          cnt <= '0;
        end
        default: begin
          state <= S_LOCK;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/swervolf_rst_seq.md
# swervolf_rst_seq

Reset sequencer for the SweRVolf SoC. It sits between the clock generator and the SoC core and owns every reset in the `clk25` domain. It releases the peripheral/DDR reset and the CPU core reset in a fixed order: PLL lock, then peripheral/DDR reset release, then DDR calibration, then core reset release. It re-sequences the core alone on watchdog or software reset requests, and reports the cause of the last reset.

## Interface
Parameters:
- `LOCK_FILTER`, default 16: consecutive cycles `i_pll_locked` must be high before sequencing starts.
- `PERIPH_HOLD`, default 32: cycles peripheral/DDR reset is held after lock is qualified.
- `CORE_HOLD`, default 64: cycles core reset is held after calibration, or after a core-only reset event.
- `CAL_TIMEOUT`, default 1048576: cycles allowed for `i_calib_done` before declaring a fault.

Ports:
- `i_clk`, in, 1: system clock (`clk25`). One clock; all logic on its rising edge.
- `i_rst`, in, 1: synchronous, active-high reset (power-on / board reset).
- `i_pll_locked`, in, 1: PLL lock indication, already synchronised to `i_clk`.
- `i_calib_done`, in, 1: DDR controller calibration complete, level.
- `i_wdt_bite`, in, 1: watchdog expiry, single-cycle pulse.
- `i_sw_rst`, in, 1: software core-reset request from syscon, single-cycle pulse.
- `o_rst_periph`, out, 1: active-high reset to bus fabric and peripherals.
- `o_rst_ddr`, out, 1: active-high reset to the DDR controller.
- `o_rst_core`, out, 1: active-high reset to the SweRV core.
- `o_ready`, out, 1: high while the system is in RUN.
- `o_cal_fail`, out, 1: calibration timeout flag, sticky.
- `o_cause`, out, 4: one-hot cause of the last reset. [0] POR, [1] lock loss, [2] watchdog, [3] software.
- `o_state`, out, 3: current state encoding, for debug and syscon readback.

## Operation
- States: `S_LOCK`, `S_PHOLD`, `S_CAL`, `S_CHOLD`, `S_RUN`, `S_FAIL`.
- A single shared counter, cleared on every state transition. It is sized by `$clog2` of the largest parameter plus 1.
- `S_LOCK`: all resets asserted.
  - Counter increments while locked and clears on any cycle with lock low.
  - When the counter reaches `LOCK_FILTER-1` with lock high, go to `S_PHOLD`.
- `S_PHOLD`: after `PERIPH_HOLD` cycles, deassert `o_rst_periph` and `o_rst_ddr`, then go to `S_CAL`.
- `S_CAL`:
  - `i_calib_done` high: go to `S_CHOLD`.
  - Counter reaches `CAL_TIMEOUT-1` without done: set `o_cal_fail` and go to `S_FAIL`.
- `S_CHOLD`: after `CORE_HOLD` cycles, deassert `o_rst_core`, set `o_ready`, and go to `S_RUN`.
- `S_RUN`: on `i_wdt_bite` or `i_sw_rst`:
  - Assert `o_rst_core` and clear `o_ready`.
  - Load `o_cause` with the event.
  - Go to `S_CHOLD`. Peripheral and DDR resets stay deasserted.
- `S_FAIL`: core reset held, peripheral/DDR reset released. Only `i_rst` or lock loss exits this state.
- Lock loss: `i_pll_locked` low in any state other than `S_LOCK`.
  - Next cycle: all three resets asserted, `o_ready` low, `o_cause` = lock loss.
  - Go to `S_LOCK`.
- Priority when events coincide: `i_rst` > lock loss > `i_wdt_bite` > `i_sw_rst`. `o_cause` records only the winner.
- Pulses on `i_wdt_bite` or `i_sw_rst` outside `S_RUN` are ignored.
- `o_cal_fail` clears only on `i_rst`.

## Timing
- Reset values (`i_rst` high) for every output:
  - `o_rst_periph`, `o_rst_ddr`, `o_rst_core` = 1.
  - `o_ready` = 0, `o_cal_fail` = 0.
  - `o_cause` = 4'b0001.
  - `o_state` = `S_LOCK`.
- All outputs are registered and change on the edge that enters the new state. There is no combinational path from inputs to outputs.
- Each counted state lasts exactly N cycles.
- Reference point for the release counts below: lock stable from the first edge with `i_rst` low.
- `o_rst_periph` and `o_rst_ddr` fall `LOCK_FILTER+PERIPH_HOLD` edges after that first edge.
- `o_rst_core` falls, and `o_ready` rises in the same edge, `CORE_HOLD` edges after the first edge sampling `i_calib_done` high in `S_CAL`.
- Watchdog or software event in `S_RUN`: `o_rst_core` rises 1 edge later and falls `CORE_HOLD` edges after that.
- Lock loss: resets assert 1 edge after `i_pll_locked` is sampled low.
- `i_rst` mid-sequence: returns to the reset values on the next edge regardless of state.

## Structure
- Shared package `swervolf_pkg` holds:
  - state enum/localparams (3-bit);
  - cause bit indices;
  - the counter-width function.
- Single flat module, no sub-modules. The lock filter reuses the shared counter.

## Test plan
Use `LOCK_FILTER`=4, `PERIPH_HOLD`=8, `CORE_HOLD`=16, `CAL_TIMEOUT`=100 throughout.
- Clean boot:
  - Stimulus: `i_rst` released with lock high; `i_calib_done` raised at cycle 20.
  - Response: periph/ddr release at cycle 12; core release and `o_ready` at cycle 36; `o_cause`=0001.
- Lock glitch during filter:
  - Stimulus: lock high 3 cycles, low 1 cycle, then high.
  - Response: periph release delayed to 12 cycles after the re-rise.
- Calibration timeout:
  - Stimulus: `i_calib_done` held low.
  - Response: `o_cal_fail`=1 after 100 cycles in `S_CAL`; `o_rst_core` stays 1; `o_rst_periph`=0.
- Watchdog in RUN:
  - Stimulus: 1-cycle `i_wdt_bite`.
  - Response: `o_rst_core` high for exactly 16 cycles; `o_ready` low for the same window; `o_cause`=0100; `o_rst_periph` stays 0.
- Coincident events:
  - Stimulus: `i_wdt_bite`, `i_sw_rst` and lock drop in the same cycle.
  - Response: all resets asserted, `o_cause`=0010, state `S_LOCK`.
- Mid-sequence reset:
  - Stimulus: `i_rst` pulse while in `S_CHOLD`.
  - Response: all outputs return to their reset values next edge, including `o_cal_fail`=0.
